// File: rtl/alu_op_sequencer.sv
// Program sequencer for the two-bit combinational ALU stage: loads up to DEPTH
// instructions, issues one every two cycles, reports each result, halts on error.
module alu_op_sequencer #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_valid,
   input  logic [1:0]    load_op,
   input  logic [1:0]    load_a,
   input  logic [1:0]    load_b,
   output logic          load_ready,
   input  logic          start,
   input  logic          clear,
   output logic          busy,
   output logic          i0,
   output logic          i1,
   output logic          a0,
   output logic          a1,
   output logic          b0,
   output logic          b1,
   input  logic          f0,
   input  logic          f1,
   input  logic          error,
   output logic          res_valid,
   output logic [1:0]    res_data,
   output logic          res_err,
   output logic [AW-1:0] res_index,
   output logic          done,
   output logic          halted_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [AW:0]   FULL    = DEPTH[AW:0];
   localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PC_ONE  = {{(AW-1){1'b0}}, 1'b1};

   state_t        state, state_n;
   logic [AW:0]   count, count_n;
   logic [AW-1:0] pc, pc_n;
   logic          load_we;
   logic [5:0]    prog [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         count <= '0;
         pc    <= '0;
      end else begin
         state <= state_n;
         count <= count_n;
         pc    <= pc_n;
      end
   end

   // A load in the same IDLE cycle as start is counted before start is judged.
   always_comb begin
      state_n = state;
      count_n = count;
      pc_n    = pc;
      load_we = 1'b0;
      case (state)
         S_IDLE: begin
            if (load_valid && (count < FULL)) begin
               load_we = 1'b1;
               count_n = count + CNT_ONE;
            end
            if (start && (count_n != '0)) begin
               pc_n    = '0;
               state_n = S_ISSUE;
            end
         end
         S_ISSUE: state_n = S_CAPTURE;
         S_CAPTURE: begin
            if (error) begin
               state_n = S_ERR;
            end else if ({1'b0, pc} == (count - CNT_ONE)) begin
               state_n = S_DONE;
            end else begin
               pc_n    = pc + PC_ONE;
               state_n = S_ISSUE;
            end
         end
         S_DONE: begin
            if (clear) begin
               count_n = '0;
               state_n = S_IDLE;
            end else if (start) begin
               pc_n    = '0;
               state_n = S_ISSUE;
            end
         end
         S_ERR: begin
            if (clear) begin
               count_n = '0;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (load_we) prog[count[AW-1:0]] <= {load_op, load_a, load_b};
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         load_ready <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         halted_err <= 1'b0;
         {i1, i0, a1, a0, b1, b0} <= '0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_err    <= 1'b0;
         res_index  <= '0;
      end else begin
         load_ready <= (state_n == S_IDLE) && (count_n < FULL);
         busy       <= (state_n == S_ISSUE) || (state_n == S_CAPTURE);
         done       <= (state_n == S_DONE);
         halted_err <= (state_n == S_ERR);
         res_valid  <= (state == S_CAPTURE);
         if (state == S_ISSUE) {i1, i0, a1, a0, b1, b0} <= prog[pc];
         if (state == S_CAPTURE) begin
            res_data  <= {f1, f0};
            res_err   <= error;
            res_index <= pc;
         end
      end
   end

endmodule
